// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Instruction-issuing front end for the 8-bit alu. Accepts one
//                32-bit instruction over valid/ready, reads operands from an
//                internal 8x8 register file, drives the alu operand/operation
//                ports for ALU_LATENCY cycles, then writes alu_result back to
//                the destination register.
//  Config      : define ALU_SEQ_SUB_EN to make opcode 0x03 (SUB) legal; when
//                undefined SUB is illegal and the negation logic is absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int ALU_LATENCY = 2          // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [7:0]  alu_data1,
    output logic [7:0]  alu_data2,
    output logic [2:0]  alu_op,
    input  logic [7:0]  alu_result,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_EXEC   = 1'b1;

    localparam logic [3:0] c_LAT       = 4'(ALU_LATENCY);

    localparam logic [7:0] c_OPC_LOADI = 8'h00;
    localparam logic [7:0] c_OPC_MOV   = 8'h01;
    localparam logic [7:0] c_OPC_ADD   = 8'h02;
`ifdef ALU_SEQ_SUB_EN
    localparam logic [7:0] c_OPC_SUB   = 8'h03;
`endif
    localparam logic [7:0] c_OPC_AND   = 8'h04;
    localparam logic [7:0] c_OPC_OR    = 8'h05;

    localparam logic [2:0] c_ALU_PASS  = 3'd0;
    localparam logic [2:0] c_ALU_ADD   = 3'd1;
    localparam logic [2:0] c_ALU_AND   = 3'd2;
    localparam logic [2:0] c_ALU_OR    = 3'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [2:0] r_dest;
    logic [7:0] r_data1;
    logic [7:0] r_data2;
    logic [2:0] r_op;
    logic       r_done;
    logic       r_err;
    logic [7:0] r_regs [8];

    // ------------------------------------------------------------------------
    // Instruction fields; register indices use only the low three bits
    // ------------------------------------------------------------------------
    logic [7:0] w_opcode;
    logic [2:0] w_dest;
    logic [2:0] w_src1;
    logic [2:0] w_src2;
    logic [7:0] w_imm;
    logic       w_unused_fields;

    assign w_opcode        = instr[31:24];
    assign w_dest          = instr[18:16];
    assign w_src1          = instr[10:8];
    assign w_src2          = instr[7:0] == 8'h00 ? 3'd0 : instr[2:0];
    assign w_imm           = instr[7:0];
    // Upper index bits are deliberately ignored
    assign w_unused_fields = ^{instr[23:19], instr[15:11]};

    // Operand values read from the current register file contents
    logic [7:0] w_rs1;
    logic [7:0] w_rs2;

    assign w_rs1 = r_regs[w_src1];
    assign w_rs2 = r_regs[w_src2];

`ifdef ALU_SEQ_SUB_EN
    // Two's-complement negation so SUB reuses the alu adder
    logic [7:0] w_rs2_neg;
    assign w_rs2_neg = (~w_rs2) + 8'd1;
`endif

    // ------------------------------------------------------------------------
    // Handshake and writeback qualifiers
    // ------------------------------------------------------------------------
    logic       w_accept;
    logic       w_wb;

    assign w_accept = instr_valid && instr_ready;
    assign w_wb     = (r_state == c_ST_EXEC) && (r_cnt == 4'd1);

    // ------------------------------------------------------------------------
    // Decode: legality and the alu port values an accepted opcode would drive
    // ------------------------------------------------------------------------
    logic       w_legal;
    logic [7:0] w_d1;
    logic [7:0] w_d2;
    logic [2:0] w_op;

    // Combinational opcode decode into alu operands and operation
    always_comb begin
        w_legal = 1'b0;
        w_d1    = 8'h00;
        w_d2    = 8'h00;
        w_op    = c_ALU_PASS;
        case (w_opcode)
            c_OPC_LOADI: begin
                w_legal = 1'b1;
                w_d2    = w_imm;
            end
            c_OPC_MOV: begin
                w_legal = 1'b1;
                w_d2    = w_rs2;
            end
            c_OPC_ADD: begin
                w_legal = 1'b1;
                w_d1    = w_rs1;
                w_d2    = w_rs2;
                w_op    = c_ALU_ADD;
            end
`ifdef ALU_SEQ_SUB_EN
            c_OPC_SUB: begin
                w_legal = 1'b1;
                w_d1    = w_rs1;
                w_d2    = w_rs2_neg;
                w_op    = c_ALU_ADD;
            end
`endif
            c_OPC_AND: begin
                w_legal = 1'b1;
                w_d1    = w_rs1;
                w_d2    = w_rs2;
                w_op    = c_ALU_AND;
            end
            c_OPC_OR: begin
                w_legal = 1'b1;
                w_d1    = w_rs1;
                w_d2    = w_rs2;
                w_op    = c_ALU_OR;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: legal accept enters EXEC, last latency cycle returns
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output logic: ready only in IDLE and never while reset is asserted
    always_comb begin
        instr_ready = (r_state == c_ST_IDLE) && !reset;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Latch alu ports and destination on a legal accept, run latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_dest  <= 3'd0;
            r_data1 <= 8'h00;
            r_data2 <= 8'h00;
            r_op    <= c_ALU_PASS;
        end else if (w_accept && w_legal) begin
            r_cnt   <= c_LAT;
            r_dest  <= w_dest;
            r_data1 <= w_d1;
            r_data2 <= w_d2;
            r_op    <= w_op;
        end else if (r_state == c_ST_EXEC) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Register file: cleared by reset, written with alu_result at writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_wb) begin
            r_regs[r_dest] <= alu_result;
        end
    end

    // One-cycle status pulses for writeback completion and illegal opcodes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_wb;
            r_err  <= w_accept && !w_legal;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_data1 = r_data1;
    assign alu_data2 = r_data2;
    assign alu_op    = r_op;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_data  = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. A behavioural alu
//                answers the sequencer's ports; expected register contents
//                and port values come from an array model of the register
//                file driven by directed and random instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  alu_data1;
    logic [7:0]  alu_data2;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int total = 0;
    int bad   = 0;
    int mregs [8];
    int pd1 = 0, pd2 = 0, pop = 0;

    alu_sequencer #(.ALU_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural alu responding to the sequencer
    always_comb begin
        case (alu_op)
            3'd0:    alu_result = alu_data2;
            3'd1:    alu_result = alu_data1 + alu_data2;
            3'd2:    alu_result = alu_data1 & alu_data2;
            3'd3:    alu_result = alu_data1 | alu_data2;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] o, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        return {o, d, s1, s2};
    endfunction

    task automatic rd(input int idx, output int val);
        dbg_addr = 3'(idx);
        #1;
        val = int'(dbg_data);
    endtask

    task automatic check_regs(input string tag);
        int v;
        for (int i = 0; i < 8; i++) begin
            rd(i, v);
            chk(tag, v, mregs[i]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        pd1 = 0; pd2 = 0; pop = 0;
    endtask

    // Issue one instruction and check its complete life cycle
    task automatic send(input logic [31:0] ins);
        int  opc, dst, a, b, imm, ed1, ed2, eop, res, n, v;
        bit  legal;
        opc = int'(ins[31:24]);
        dst = int'(ins[18:16]);
        a   = mregs[ins[10:8]];
        b   = mregs[ins[2:0]];
        imm = int'(ins[7:0]);
        legal = 1'b1; ed1 = 0; ed2 = 0; eop = 0; res = 0;
        case (opc)
            0: begin ed2 = imm; res = imm; end
            1: begin ed2 = b;   res = b;   end
            2: begin ed1 = a; ed2 = b; eop = 1; res = (a + b) % 256; end
`ifdef ALU_SEQ_SUB_EN
            3: begin ed1 = a; ed2 = (256 - b) % 256; eop = 1; res = (a - b + 256) % 256; end
`endif
            4: begin ed1 = a; ed2 = b; eop = 2; res = a & b; end
            5: begin ed1 = a; ed2 = b; eop = 3; res = a | b; end
            default: legal = 1'b0;
        endcase

        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        instr_valid = 1'b0;

        if (legal) begin
            chk("op_data1", int'(alu_data1), ed1);
            chk("op_data2", int'(alu_data2), ed2);
            chk("op_code",  int'(alu_op),    eop);
            chk("exec_err", int'(err),       0);
            pd1 = ed1; pd2 = ed2; pop = eop;
            n = 1;
            while (!done && n < 40) begin
                chk("exec_ready", int'(instr_ready), 0);
                @(negedge clk);
                n++;
            end
            chk("done_latency", n, LAT + 1);
            chk("ready_at_done", int'(instr_ready), 1);
            mregs[dst] = res;
            rd(dst, v);
            chk("wb_dbg", v, res);
            @(negedge clk);
            chk("done_pulse", int'(done), 0);
        end else begin
            chk("ill_err",   int'(err),         1);
            chk("ill_done",  int'(done),        0);
            chk("ill_ready", int'(instr_ready), 1);
            chk("ill_d1",    int'(alu_data1),   pd1);
            chk("ill_d2",    int'(alu_data2),   pd2);
            chk("ill_op",    int'(alu_op),      pop);
            @(negedge clk);
            chk("ill_err_pulse", int'(err), 0);
            check_regs("ill_regs");
        end
    endtask

    task automatic b2b_test();
        int cyc, nacc, zeros, last, n, v;
        int acc [2];
        cyc = 0; nacc = 0; zeros = 0; last = 0;
        acc[0] = 0; acc[1] = 0;
        @(negedge clk);
        instr       = mk(8'h02, 8'h01, 8'h01, 8'h01);
        instr_valid = 1'b1;
        while (cyc < 40) begin
            if (instr_ready) begin
                acc[nacc] = cyc;
                last = cyc;
                nacc++;
            end else if (nacc == 1) begin
                zeros++;
            end
            @(negedge clk);
            cyc++;
            if (nacc > 0 && cyc == last + 1) begin
                chk("b2b_d1", int'(alu_data1), nacc == 1 ? 3 : 6);
                chk("b2b_d2", int'(alu_data2), nacc == 1 ? 3 : 6);
            end
            if (nacc == 2) break;
        end
        instr_valid = 1'b0;
        chk("b2b_accepts", nacc, 2);
        chk("b2b_gap", acc[1] - acc[0], LAT + 1);
        chk("b2b_ready_low", zeros, LAT);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_lat", n, LAT + 1);
        mregs[1] = 12;
        pd1 = 6; pd2 = 6; pop = 1;
        rd(1, v);
        chk("b2b_r1", v, 12);
        @(negedge clk);
    endtask

    task automatic reset_abort();
        int v;
        @(negedge clk);
        instr       = mk(8'h02, 8'h03, 8'h01, 8'h02);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("abort_in_exec", int'(instr_ready), 0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_done_rst",  int'(done),        0);
            chk("abort_ready_rst", int'(instr_ready), 0);
        end
        reset = 1'b0;
        model_clear();
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("abort_done_after", int'(done), 0);
        end
        check_regs("abort_regs");
        chk("abort_d1", int'(alu_data1), 0);
        chk("abort_d2", int'(alu_data2), 0);
        chk("abort_op", int'(alu_op),    0);
        rd(3, v);
        chk("abort_r3", v, 0);
    endtask

    initial begin
        int v;
        logic [7:0] o, d, s1, s2;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        dbg_addr    = 3'd0;
        model_clear();

        // Reset for two cycles
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", int'(instr_ready), 0);
            chk("rst_done",  int'(done),        0);
            chk("rst_err",   int'(err),         0);
            chk("rst_d1",    int'(alu_data1),   0);
            chk("rst_d2",    int'(alu_data2),   0);
            chk("rst_op",    int'(alu_op),      0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_rst", int'(instr_ready), 1);
        check_regs("rst_regs");

        // LOADI, ADD/AND/OR
        send(mk(8'h00, 8'h01, 8'h00, 8'h03));
        send(mk(8'h00, 8'h02, 8'h00, 8'h04));
        rd(1, v); chk("r1_loadi", v, 3);
        rd(2, v); chk("r2_loadi", v, 4);
        send(mk(8'h02, 8'h03, 8'h01, 8'h02));
        send(mk(8'h04, 8'h04, 8'h01, 8'h02));
        send(mk(8'h05, 8'h05, 8'h01, 8'h02));
        rd(3, v); chk("r3_add", v, 8'h07);
        rd(4, v); chk("r4_and", v, 8'h00);
        rd(5, v); chk("r5_or",  v, 8'h07);

        // SUB: legal only when the option is built in
        send(mk(8'h03, 8'h06, 8'h01, 8'h02));
        rd(6, v);
`ifdef ALU_SEQ_SUB_EN
        chk("r6_sub", v, 8'hFF);
`else
        chk("r6_sub", v, 8'h00);
`endif

        // Wrap-around
        send(mk(8'h00, 8'h00, 8'h00, 8'hFF));
        send(mk(8'h00, 8'h07, 8'h00, 8'h02));
        send(mk(8'h02, 8'h00, 8'h00, 8'h07));
        rd(0, v); chk("r0_wrap", v, 8'h01);

        // Back-to-back dependency from r1 = 3
        send(mk(8'h00, 8'h01, 8'h00, 8'h03));
        b2b_test();
        check_regs("b2b_regs");

        // Illegal opcode
        send(mk(8'h07, 8'h01, 8'h02, 8'h03));

        // Reset abort during ADD
        send(mk(8'h00, 8'h01, 8'h00, 8'h05));
        send(mk(8'h00, 8'h02, 8'h00, 8'h09));
        reset_abort();

        // Randomized instruction stream with random upper index bits
        for (int k = 0; k < 120; k++) begin
            v = $urandom_range(0, 9);
            o  = (v <= 7) ? 8'(v) : 8'($urandom_range(8, 255));
            d  = 8'($urandom);
            s1 = 8'($urandom);
            s2 = 8'($urandom);
            send(mk(o, d, s1, s2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ((k % 20) == 19) check_regs("rand_regs");
        end
        check_regs("final_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-issuing front end for the 8-bit `alu`. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads operands from an internal 8×8 register file. It drives the ALU operand and operation inputs, waits a fixed number of cycles for the ALU result, then writes the result back. It sits between instruction fetch and the `alu`, and is the initiator side of the `data1`/`data2`/`operation`/`result` interface.

## Interface
- `ALU_LATENCY`, default 2: cycles the ALU ports are held stable before `alu_result` is sampled; legal range 1–15.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `instr`  in  32  fields: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or imm.
- `alu_data1`  out  8  ALU operand 1.
- `alu_data2`  out  8  ALU operand 2.
- `alu_op`  out  3  ALU operation: 0 forward data2, 1 add, 2 and, 3 or.
- `alu_result`  in  8  ALU result.
- `done`  out  1  one-cycle pulse after a writeback.
- `err`  out  1  one-cycle pulse after an illegal opcode is accepted.
- `dbg_addr`  in  3  debug register select.
- `dbg_data`  out  8  combinational read of `reg[dbg_addr]`.

## Operation
- Register file: 8 × 8-bit registers. Indexing uses only bits [2:0] of the dest, src1 and src2 fields; the upper bits are ignored.
- Opcodes:
  - 0x00 LOADI: data1=0, data2=imm, op=0.
  - 0x01 MOV: data1=0, data2=reg[src2], op=0.
  - 0x02 ADD: reg[src1], reg[src2], op=1.
  - 0x03 SUB: data1=reg[src1], data2=(~reg[src2]+1) mod 256, op=1.
  - 0x04 AND: reg[src1], reg[src2], op=2.
  - 0x05 OR: reg[src1], reg[src2], op=3.
  - Any other opcode is illegal.
- All arithmetic is 8-bit and wraps; no carry or flags are produced.
- FSM states are IDLE and EXEC.
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready` with a legal opcode, register the ALU ports from the current register file contents, load the counter with ALU_LATENCY, and go to EXEC.
  - An illegal opcode is consumed with no ALU port change and no write. `err`=1 next cycle; the state stays IDLE.
  - EXEC: `instr_ready`=0 and ALU ports held. The counter decrements each edge. On the edge where the counter equals 1, write `alu_result` to reg[dest], set `done`=1 for the next cycle, and return to IDLE.
  - `instr_valid` while in EXEC is ignored; the instruction is not consumed.
- ALU ports keep their last values while IDLE.

## Timing
- Reset (synchronous, dominant over every other input):
  - All registers = 0; state IDLE.
  - `alu_data1`/`alu_data2`/`alu_op` = 0; `done`=0; `err`=0.
  - `instr_ready` = 0 while `reset` is high, and 1 in the first cycle after release.
- Accept at edge E0 drives the ALU ports from E0.
- Writeback occurs at edge E0+ALU_LATENCY. `done` is high during the following cycle, and `instr_ready` is 1 in that same cycle.
- Maximum throughput is one instruction per ALU_LATENCY+1 cycles.
- Operands are read at the accept edge, after the previous writeback edge, so a dependent back-to-back instruction sees the updated value. No forwarding is needed.
- Reset asserted during EXEC aborts the instruction: no writeback and no `done`.
- `dbg_data` reflects a write in the cycle after the writeback edge.

## Configuration
- `ALU_SEQ_SUB_EN` defined: opcode 0x03 (SUB) is legal and executes as above.
- Not defined: 0x03 is illegal (`err` pulse, no write), and the two's-complement negation logic is absent.

## Test plan
- **Reset, then LOADI:** reset 2 cycles; then LOADI r1,#3 and LOADI r2,#4 (ALU_LATENCY=2).
  - Required: `instr_ready`=1 in the first cycle after reset release.
  - Required: `done` pulses 3 cycles after each accept; `dbg_data`(r1)=3 and (r2)=4.
- **ADD/AND/OR:** ADD r3,r1,r2; AND r4,r1,r2; OR r5,r1,r2.
  - Required during the ADD: `alu_data1`=3, `alu_data2`=4, `alu_op`=1.
  - Required results: r3=0x07, r4=0x00, r5=0x07.
- **SUB with `ALU_SEQ_SUB_EN`:** SUB r6,r1,r2 → `alu_data2`=0xFC, r6=0xFF.
  - Without the macro: `err` pulse, no `done`, r6 stays 0x00.
- **Wrap:** LOADI r0,#0xFF; LOADI r7,#0x02; ADD r0,r0,r7 → r0=0x01.
- **Back-to-back dependency:** `instr_valid` held high with ADD r1,r1,r1 issued twice from r1=3.
  - Required: accepts exactly 3 cycles apart; r1=6, then r1=12.
  - Required: `instr_ready`=0 throughout EXEC.
- **Illegal opcode and reset abort:**
  - Opcode 0x07 → `err` for 1 cycle, `instr_ready` stays 1, no register changes.
  - Reset asserted in the middle of an ADD's EXEC → no `done`, all registers read 0 after release.
